// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for a 5-stage pipeline: stage hold/flush controls,
// EX forwarding selects, data-memory wait tracking and saturating perf counters.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic             mem_to_reg_e,
    input  logic [4:0]       rd_m,
    input  logic             reg_w_en_m,
    input  logic [4:0]       rd_w,
    input  logic             reg_w_en_w,
    input  logic             redirect_e,
    input  logic             dmem_req_m,
    input  logic             dmem_ready,
    output logic             bubbleF,
    output logic             bubbleD,
    output logic             bubbleE,
    output logic             bubbleM,
    output logic             bubbleW,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic             flushW,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_t;

    state_t             state_r;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic               mem_timeout_r;
    logic [CNT_W-1:0]   stall_cnt_r;
    logic [CNT_W-1:0]   flush_cnt_r;
    logic               frozen_s;
    logic               redirect_s;
    logic               load_use_s;
    logic [1:0]         fwd_a_s;
    logic [1:0]         fwd_b_s;

    // MEM result is younger than WB, so it wins when both write the same register.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] dst_m,
        input logic       en_m,
        input logic [4:0] dst_w,
        input logic       en_w
    );
        logic [1:0] sel;
        if (en_m && (dst_m != 5'd0) && (dst_m == src)) begin
            sel = 2'b10;
        end else if (en_w && (dst_w != 5'd0) && (dst_w == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Hazard classification; everything is held at zero while reset is asserted.
    always_comb begin
        frozen_s   = 1'b0;
        redirect_s = 1'b0;
        load_use_s = 1'b0;
        fwd_a_s    = 2'b00;
        fwd_b_s    = 2'b00;
        if (!rstn) begin
            frozen_s = 1'b0;
        end else begin
            frozen_s   = !dmem_ready && ((state_r == ST_WAIT) || dmem_req_m);
            redirect_s = !frozen_s && redirect_e;
            load_use_s = !frozen_s && !redirect_e && mem_to_reg_e && (rd_e != 5'd0) &&
                         ((rd_e == rs1_d) || (rd_e == rs2_d));
            fwd_a_s    = fwd_sel(rs1_e, rd_m, reg_w_en_m, rd_w, reg_w_en_w);
            fwd_b_s    = fwd_sel(rs2_e, rd_m, reg_w_en_m, rd_w, reg_w_en_w);
        end
    end

    assign bubbleF     = frozen_s | load_use_s;
    assign bubbleD     = frozen_s | load_use_s;
    assign bubbleE     = frozen_s;
    assign bubbleM     = frozen_s;
    assign bubbleW     = 1'b0;
    assign flushD      = redirect_s;
    assign flushE      = redirect_s | load_use_s;
    assign flushM      = 1'b0;
    assign flushW      = frozen_s;
    assign fwd_a_sel   = fwd_a_s;
    assign fwd_b_sel   = fwd_b_s;
    assign mem_timeout = mem_timeout_r;
    assign stall_cnt   = stall_cnt_r;
    assign flush_cnt   = flush_cnt_r;

    // Memory-wait FSM with saturating wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r       <= ST_RUN;
            wait_cnt_r    <= '0;
            mem_timeout_r <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    wait_cnt_r <= '0;
                    if (dmem_req_m && !dmem_ready) begin
                        state_r <= ST_WAIT;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_r != WAIT_MAX) begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    end else begin
                        wait_cnt_r <= wait_cnt_r;
                    end
                    if (wait_cnt_r >= (WAIT_MAX - WAIT_W'(1))) begin
                        mem_timeout_r <= 1'b1;
                    end else begin
                        mem_timeout_r <= mem_timeout_r;
                    end
                    if (dmem_ready) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    state_r    <= ST_RUN;
                    wait_cnt_r <= '0;
                end
            endcase
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else begin
            if (bubbleF && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (redirect_s && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_W'(1);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl against a rule-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int T_OUT = 4;
    localparam int CW    = 8;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rstn;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic mem_to_reg_e, reg_w_en_m, reg_w_en_w, redirect_e, dmem_req_m, dmem_ready;
    logic bubbleF, bubbleD, bubbleE, bubbleM, bubbleW, flushD, flushE, flushM, flushW;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic mem_timeout;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit m_wait;
    int m_wcnt;
    bit m_tmo;
    int m_sc;
    int m_fc;
    bit e_frozen, e_redir, e_lu;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(T_OUT), .CNT_W(CW)) dut (
        .clk(clk), .rstn(rstn),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .mem_to_reg_e(mem_to_reg_e),
        .rd_m(rd_m), .reg_w_en_m(reg_w_en_m), .rd_w(rd_w), .reg_w_en_w(reg_w_en_w),
        .redirect_e(redirect_e), .dmem_req_m(dmem_req_m), .dmem_ready(dmem_ready),
        .bubbleF(bubbleF), .bubbleD(bubbleD), .bubbleE(bubbleE), .bubbleM(bubbleM),
        .bubbleW(bubbleW), .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int fwd_model(input logic [4:0] x);
        if (reg_w_en_m && rd_m != 0 && rd_m == x) return 2;
        if (reg_w_en_w && rd_w != 0 && rd_w == x) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_wait = 0; m_wcnt = 0; m_tmo = 0; m_sc = 0; m_fc = 0;
    endtask

    task automatic idle();
        {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
        {mem_to_reg_e, reg_w_en_m, reg_w_en_w, redirect_e, dmem_req_m, dmem_ready} = '0;
    endtask

    task automatic check_all();
        logic [8:0] ctrl_exp, ctrl_obs;
        int fa, fb;
        e_frozen = rstn && !dmem_ready && (m_wait || dmem_req_m);
        e_redir  = rstn && !e_frozen && redirect_e;
        e_lu     = rstn && !e_frozen && !redirect_e && mem_to_reg_e && rd_e != 0 &&
                   (rd_e == rs1_d || rd_e == rs2_d);
        ctrl_exp = {e_frozen || e_lu, e_frozen || e_lu, e_frozen, e_frozen, 1'b0,
                    e_redir, e_redir || e_lu, 1'b0, e_frozen};
        ctrl_obs = {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW, flushD, flushE, flushM, flushW};
        fa = rstn ? fwd_model(rs1_e) : 0;
        fb = rstn ? fwd_model(rs2_e) : 0;
        check_eq("ctrl", 32'(ctrl_obs), 32'(ctrl_exp));
        check_eq("fwd_a", 32'(fwd_a_sel), 32'(fa));
        check_eq("fwd_b", 32'(fwd_b_sel), 32'(fb));
        check_eq("mem_timeout", 32'(mem_timeout), 32'(m_tmo));
        check_eq("stall_cnt", 32'(stall_cnt), 32'(m_sc));
        check_eq("flush_cnt", 32'(flush_cnt), 32'(m_fc));
    endtask

    task automatic model_advance();
        if (!rstn) begin
            model_reset();
        end else begin
            if (m_wait) begin
                m_wcnt = (m_wcnt + 1 > T_OUT) ? T_OUT : m_wcnt + 1;
                if (m_wcnt >= T_OUT) m_tmo = 1;
                if (dmem_ready) m_wait = 0;
            end else begin
                m_wcnt = 0;
                if (dmem_req_m && !dmem_ready) m_wait = 1;
            end
            if ((e_frozen || e_lu) && m_sc < CMAX) m_sc++;
            if (e_redir && m_fc < CMAX) m_fc++;
        end
    endtask

    // Check at the falling edge, advance the model, then return #1 after the rising edge.
    task automatic cycle();
        @(negedge clk);
        check_all();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rstn = 1'b0;
        model_reset();
        cycle();
        cycle();
        rstn = 1'b1;
        cycle();

        // load-use, then the same with rd_e = 0
        mem_to_reg_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5;
        cycle();
        check_eq("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        rd_e = 5'd0; rs1_d = 5'd0;
        cycle();
        // redirect together with load-use
        rd_e = 5'd5; rs2_d = 5'd5; redirect_e = 1'b1;
        cycle();
        check_eq("redir_flush_cnt", 32'(flush_cnt), 32'd1);
        idle();
        // memory wait of three cycles, then ready
        dmem_req_m = 1'b1;
        repeat (3) cycle();
        dmem_ready = 1'b1;
        cycle();
        check_eq("wait_stall_cnt", 32'(stall_cnt), 32'd4);
        idle();
        cycle();
        // long wait triggers the sticky timeout
        dmem_req_m = 1'b1;
        repeat (10) cycle();
        dmem_ready = 1'b1;
        cycle();
        idle();
        cycle();
        check_eq("tmo_sticky", 32'(mem_timeout), 32'd1);
        // forwarding priority
        rd_m = 5'd7; rd_w = 5'd7; reg_w_en_m = 1'b1; reg_w_en_w = 1'b1; rs1_e = 5'd7;
        cycle();
        reg_w_en_m = 1'b0;
        cycle();
        rs2_e = 5'd0; rd_m = 5'd0; reg_w_en_m = 1'b1;
        cycle();

        for (int i = 0; i < 800; i++) begin
            rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
            rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
            rd_e  = 5'($urandom_range(0, 3)); rd_m  = 5'($urandom_range(0, 3));
            rd_w  = 5'($urandom_range(0, 3));
            mem_to_reg_e = 1'($urandom_range(0, 1));
            reg_w_en_m   = 1'($urandom_range(0, 1));
            reg_w_en_w   = 1'($urandom_range(0, 1));
            redirect_e   = ($urandom_range(0, 3) == 0);
            dmem_req_m   = ($urandom_range(0, 2) == 0);
            dmem_ready   = ($urandom_range(0, 2) == 0);
            cycle();
        end

        // asynchronous reset in the middle of a memory wait
        idle();
        dmem_req_m = 1'b1; rd_m = 5'd3; reg_w_en_m = 1'b1; rs1_e = 5'd3; rs2_e = 5'd3;
        cycle();
        cycle();
        check_eq("pre_rst_bubbleF", 32'(bubbleF), 32'd1);
        rstn = 1'b0;
        #1;
        check_eq("rst_ctrl", 32'({bubbleF, bubbleD, bubbleE, bubbleM, flushD, flushE, flushW}), 32'd0);
        check_eq("rst_fwd", 32'({fwd_a_sel, fwd_b_sel}), 32'd0);
        check_eq("rst_cnts", 32'({stall_cnt, flush_cnt, 7'd0, mem_timeout}), 32'd0);
        model_reset();
        dmem_req_m = 1'b0;
        cycle();
        rstn = 1'b1;
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
